// File: rtl/rvfi_bmc_pkg.sv
// Shared types for the RVFI BMC sequencer: FSM state encoding and the
// wait-counter width helper.
package rvfi_bmc_pkg;

  typedef enum logic [1:0] {
    S_RESET,
    S_RUN,
    S_CHECK,
    S_DONE
  } bmc_state_t;

  // The counter must be able to hold MAX_WAIT+1 so that a violation is representable.
  function automatic int wait_w(input int max_wait);
    return $clog2(max_wait + 2);
  endfunction

endpackage

// File: rtl/rvfi_bmc_sequencer_if.sv
// Valid/ready memory-channel bundle observed by the BMC sequencer.
// The harness drives it as master; the sequencer only listens.
interface rvfi_bmc_sequencer_if #(
  parameter int NCHAN = 1
) ();

  logic [NCHAN-1:0] mem_valid;
  logic [NCHAN-1:0] mem_ready;

  modport master (
    output mem_valid,
    output mem_ready
  );

  modport slave (
    input mem_valid,
    input mem_ready
  );

endinterface

// File: rtl/rvfi_bmc_wait_ctr.sv
// Per-channel bounded-wait tracker: counts consecutive stalled cycles and
// latches a sticky protocol error when valid is withdrawn mid-wait.
module rvfi_bmc_wait_ctr
  import rvfi_bmc_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_i,
  input  logic ready_i,
  output logic stall_viol_o,
  output logic proto_err_o
);

  localparam int W = wait_w(MAX_WAIT);
  localparam logic [W-1:0] LIMIT = W'(MAX_WAIT);
  localparam logic [W-1:0] SAT   = W'(MAX_WAIT + 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         proto_q, proto_d;
  logic         stall;

  // A non-zero count means the previous cycle was a stall, so no separate history flop is needed.
  always_comb begin
    stall   = valid_i & ~ready_i;
    cnt_d   = '0;
    proto_d = proto_q | ((cnt_q != '0) & ~valid_i);
    if (stall) begin
      cnt_d = (cnt_q == SAT) ? cnt_q : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      proto_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      proto_q <= proto_d;
    end
  end

  assign stall_viol_o = (cnt_q > LIMIT);
  assign proto_err_o  = proto_q;

endmodule

// File: rtl/rvfi_bmc_sequencer.sv
// Run control (DUT reset, one-shot check enable, saturating cycle count) and
// per-channel bus fairness for RVFI harnesses. Optional trap gating: RVFI_BMC_SEQ_TRAP_EN.
module rvfi_bmc_sequencer
  import rvfi_bmc_pkg::*;
#(
  parameter int NCHAN        = 1,
  parameter int RESET_CYCLES = 1,
  parameter int BMC_DEPTH    = 20,
  parameter int CYCLE_W      = 8,
  parameter int MAX_WAIT     = 4
) (
  input  logic                clk,
  input  logic                reset,
  rvfi_bmc_sequencer_if.slave mem,
  input  logic                trap,
  output logic                dut_resetn,
  output logic                check_en,
  output logic [CYCLE_W-1:0]  cycle,
  output logic [NCHAN-1:0]    stall_viol,
  output logic [NCHAN-1:0]    proto_err,
  output logic                assume_ok
);

  localparam logic [CYCLE_W-1:0] CYCLE_MAX  = '1;
  localparam logic [CYCLE_W-1:0] RESET_LAST = CYCLE_W'(RESET_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] CHECK_LAST = CYCLE_W'(BMC_DEPTH - 1);

  bmc_state_t         state_q;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic               dut_resetn_q;
  logic               check_q;
  logic               trapped;

  assign cycle_d = (cycle_q == CYCLE_MAX) ? cycle_q : cycle_q + CYCLE_W'(1);

  // Outputs are registered alongside the state so they change exactly with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RESET;
      cycle_q      <= '0;
      dut_resetn_q <= 1'b0;
      check_q      <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      case (state_q)
        S_RESET: begin
          if (cycle_q == RESET_LAST) begin
            state_q      <= S_RUN;
            dut_resetn_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (cycle_q == CHECK_LAST) begin
            state_q <= S_CHECK;
            check_q <= 1'b1;
          end
        end
        S_CHECK: begin
          state_q <= S_DONE;
          check_q <= 1'b0;
        end
        default: begin
          state_q <= S_DONE;
          check_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef RVFI_BMC_SEQ_TRAP_EN
  logic trapped_q;

  // Trap during DUT reset is meaningless, so it only counts once the DUT is running.
  always_ff @(posedge clk) begin
    if (reset) begin
      trapped_q <= 1'b0;
    end else if (trap && dut_resetn_q) begin
      trapped_q <= 1'b1;
    end
  end

  assign trapped = trapped_q;
`else
  logic trap_unused;

  assign trap_unused = trap;
  assign trapped     = 1'b0;
`endif

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    rvfi_bmc_wait_ctr #(
      .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
      .clk          (clk),
      .reset        (reset),
      .valid_i      (mem.mem_valid[i]),
      .ready_i      (mem.mem_ready[i]),
      .stall_viol_o (stall_viol[i]),
      .proto_err_o  (proto_err[i])
    );
  end

  assign dut_resetn = dut_resetn_q;
  assign check_en   = check_q & ~trapped;
  assign cycle      = cycle_q;
  assign assume_ok  = ~|stall_viol & ~|proto_err & ~trapped;

endmodule

// File: tb/tb_rvfi_bmc_sequencer.sv
// Scoreboard bench for rvfi_bmc_sequencer: directed stimulus pushes expected
// outputs for the next edge, a monitor pops and compares after every edge.
module tb_rvfi_bmc_sequencer;

  localparam int NCHAN = 2;
`ifdef RVFI_BMC_SEQ_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum int {F_RESETN, F_CHECK, F_CYCLE, F_STALL, F_PROTO, F_OK} field_t;

  typedef struct {
    int     due;
    field_t field;
    int     exp;
    string  name;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             trap;
  logic             dutResetn;
  logic             checkEn;
  logic [7:0]       cycle;
  logic [NCHAN-1:0] stallViol;
  logic [NCHAN-1:0] protoErr;
  logic             assumeOk;

  exp_t sbQueue[$];
  int   tbCyc    = 0;
  int   checkCnt = 0;
  int   passCnt  = 0;

  always #5 clk = ~clk;

  rvfi_bmc_sequencer_if #(.NCHAN(NCHAN)) memIf ();

  rvfi_bmc_sequencer #(
    .NCHAN        (NCHAN),
    .RESET_CYCLES (1),
    .BMC_DEPTH    (20),
    .CYCLE_W      (8),
    .MAX_WAIT     (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem        (memIf),
    .trap       (trap),
    .dut_resetn (dutResetn),
    .check_en   (checkEn),
    .cycle      (cycle),
    .stall_viol (stallViol),
    .proto_err  (protoErr),
    .assume_ok  (assumeOk)
  );

  function automatic int actual(input field_t f);
    case (f)
      F_RESETN: return int'(dutResetn);
      F_CHECK:  return int'(checkEn);
      F_CYCLE:  return int'(cycle);
      F_STALL:  return int'(stallViol);
      F_PROTO:  return int'(protoErr);
      default:  return int'(assumeOk);
    endcase
  endfunction

  task automatic checkOutput(input exp_t e);
    int a;
    a = actual(e.field);
    checkCnt++;
    if (a == e.exp) begin
      passCnt++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (tb cycle %0d)", e.name, a, e.exp, tbCyc);
    end
  endtask

  // Inputs change on the falling edge; one call covers one clock cycle.
  task automatic applyStimulus(input logic rstV, input logic [NCHAN-1:0] validV,
                               input logic [NCHAN-1:0] readyV, input logic trapV);
    @(negedge clk);
    reset           = rstV;
    memIf.mem_valid = validV;
    memIf.mem_ready = readyV;
    trap            = trapV;
  endtask

  task automatic expectAfter(input string name, input field_t f, input int v);
    exp_t e;
    e.due   = tbCyc + 1;
    e.field = f;
    e.exp   = v;
    e.name  = name;
    sbQueue.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      tbCyc++;
      #1;
      while (sbQueue.size() > 0 && sbQueue[0].due <= tbCyc) begin
        e = sbQueue.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    exp_t e;
    reset           = 1'b1;
    trap            = 1'b0;
    memIf.mem_valid = '0;
    memIf.mem_ready = '0;

    $display("[TB] reset values");
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0);
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0);
    expectAfter("rst_resetn", F_RESETN, 0);
    expectAfter("rst_check",  F_CHECK,  0);
    expectAfter("rst_cycle",  F_CYCLE,  0);
    expectAfter("rst_stall",  F_STALL,  0);
    expectAfter("rst_proto",  F_PROTO,  0);
    expectAfter("rst_ok",     F_OK,     1);

    $display("[TB] run sequencing and cycle saturation");
    for (int k = 1; k <= 260; k++) begin
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b0);
      expectAfter("t1_check", F_CHECK, int'(k == 20));
      if (k == 1) expectAfter("t1_resetn", F_RESETN, 1);
      if (k == 1 || k == 19 || k == 20 || k == 21 || k == 254 || k == 255 || k == 260)
        expectAfter("t1_cycle", F_CYCLE, (k > 255) ? 255 : k);
    end

    $display("[TB] stall detection on channel 0");
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 2'b01, 2'b00, 1'b0);
      expectAfter("t2_stall", F_STALL, (k == 5) ? 1 : 0);
      expectAfter("t2_ok",    F_OK,    (k == 5) ? 0 : 1);
    end
    applyStimulus(1'b0, 2'b01, 2'b01, 1'b0);
    expectAfter("t2_stall_clr", F_STALL, 0);
    expectAfter("t2_ok_clr",    F_OK,    1);
    expectAfter("t2_proto",     F_PROTO, 0);

    $display("[TB] ready at the wait limit");
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 2'b01, 2'b00, 1'b0);
      expectAfter("t2b_stall", F_STALL, 0);
    end
    applyStimulus(1'b0, 2'b01, 2'b01, 1'b0);
    expectAfter("t2b_stall_rdy", F_STALL, 0);
    expectAfter("t2b_ok_rdy",    F_OK,    1);
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b0);
    expectAfter("t2b_proto", F_PROTO, 0);

    $display("[TB] counter saturation on channel 1");
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b0, 2'b10, 2'b00, 1'b0);
      expectAfter("t2c_stall", F_STALL, (k >= 5) ? 2 : 0);
    end
    applyStimulus(1'b0, 2'b10, 2'b10, 1'b0);
    expectAfter("t2c_stall_clr", F_STALL, 0);

    $display("[TB] protocol error on dropped valid");
    applyStimulus(1'b0, 2'b01, 2'b00, 1'b0);
    expectAfter("t3_proto_1", F_PROTO, 0);
    applyStimulus(1'b0, 2'b01, 2'b00, 1'b0);
    expectAfter("t3_proto_2", F_PROTO, 0);
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b0);
    expectAfter("t3_proto_3", F_PROTO, 1);
    expectAfter("t3_ok",      F_OK,    0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b0);
      expectAfter("t3_sticky", F_PROTO, 1);
    end
    applyStimulus(1'b0, 2'b01, 2'b01, 1'b0);
    expectAfter("t3_sticky_rdy", F_PROTO, 1);

    $display("[TB] reset mid-run");
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b0, (k == 10 || k == 11) ? 2'b01 : 2'b00, 2'b00, 1'b0);
    end
    expectAfter("t4_pre_cycle", F_CYCLE, 12);
    expectAfter("t4_pre_proto", F_PROTO, 1);
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0);
    expectAfter("t4_resetn", F_RESETN, 0);
    expectAfter("t4_cycle",  F_CYCLE,  0);
    expectAfter("t4_proto",  F_PROTO,  0);
    for (int k = 1; k <= 21; k++) begin
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b0);
      expectAfter("t4_check", F_CHECK, int'(k == 20));
      if (k == 1)  expectAfter("t4_resetn_up", F_RESETN, 1);
      if (k == 20) expectAfter("t4_cycle20",   F_CYCLE,  20);
    end

    $display("[TB] trap handling (gating enabled = %0d)", TRAP_EN);
    applyStimulus(1'b1, 2'b00, 2'b00, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b0);
    end
    expectAfter("t5_ok_pre", F_OK, 1);
    applyStimulus(1'b0, 2'b00, 2'b00, 1'b1);
    expectAfter("t5_ok_trap", F_OK, TRAP_EN ? 0 : 1);
    for (int k = 12; k <= 22; k++) begin
      applyStimulus(1'b0, 2'b00, 2'b00, 1'b0);
      expectAfter("t5_check", F_CHECK, int'(k == 20 && !TRAP_EN));
      expectAfter("t5_ok",    F_OK,    TRAP_EN ? 0 : 1);
    end

    @(posedge clk);
    #2;
    while (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkCnt++;
      $display("[TB] FAIL %s: got no sample, expected %0d", e.name, e.exp);
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
